// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch-request controller for the IF stage.
//
// This block holds the current fetch address and drives a valid/grant request
// to instruction memory. The next PC is chosen in this order: trap, redirect,
// buffered (pending) redirect, then the sequential increment. A trap or
// redirect that arrives while the request cannot be accepted goes into a
// one-entry pending buffer, so the address on the bus stays stable.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to replace misaligned redirect
// targets with trap_vec_i. The replacement is signalled on misalign_o.
//
// Ports:
//   clk_i, rst_i          clock (rising edge) and async active-low reset
//   stall_i               hold the PC
//   redirect_i/_pc_i      branch/jump pulse and target
//   trap_i/trap_vec_i     trap pulse and handler address
//   halt_i                enter HALT after the current accepted request
//   imem_gnt_i            memory accepts the current request
//   imem_req_o            fetch request valid
//   pc_o, pc_plus_o       current fetch address, pc_o + INC
//   fetch_vld_o/_pc_o     accepted-request pulse and its address
//   halted_o              high in HALT
//   misalign_o            (PC_MISALIGN_TRAP_EN only) misaligned redirect replaced
module pc_fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            imem_gnt_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_vld_o,
    output logic [XLEN-1:0] fetch_pc_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            misalign_o,
`endif
    output logic            halted_o
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_vld_q, fetch_vld_d;
    logic            pend_vld_q, pend_vld_d;
    logic            pend_trap_q, pend_trap_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] redir_tgt;
    logic            acc;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic redir_bad;
    assign redir_bad = |redirect_pc_i[1:0];
    assign redir_tgt = redir_bad ? trap_vec_i : redirect_pc_i;
    assign misalign_o = misalign_q;
`else
    assign redir_tgt = redirect_pc_i;
`endif

    assign acc         = (state_q == RUN) && imem_gnt_i && !stall_i;
    assign pc_plus_o   = pc_q + XLEN'(INC);
    assign pc_o        = pc_q;
    assign imem_req_o  = (state_q == RUN);
    assign halted_o    = (state_q == HALT);
    assign fetch_vld_o = fetch_vld_q;
    assign fetch_pc_o  = fetch_pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_vld_d = 1'b0;
        fetch_pc_d  = fetch_pc_q;
        pend_vld_d  = pend_vld_q;
        pend_trap_d = pend_trap_q;
        pend_pc_d   = pend_pc_q;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (acc) begin
                    fetch_vld_d = 1'b1;
                    fetch_pc_d  = pc_q;
                    pend_vld_d  = 1'b0;
                    if (trap_i) begin
                        pc_d = trap_vec_i;
                    end else if (redirect_i) begin
                        pc_d = redir_tgt;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign_d = redir_bad;
`endif
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_plus_o;
                    end
                    if (halt_i) state_d = HALT;
                end
            end
            HALT: begin
                // A pending entry is consumed here as well, so HALT does not
                // discard a redirect that was buffered earlier.
                if (trap_i || redirect_i || pend_vld_q) begin
                    state_d    = RUN;
                    pend_vld_d = 1'b0;
                    if (trap_i) begin
                        pc_d = trap_vec_i;
                    end else if (redirect_i) begin
                        pc_d = redir_tgt;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign_d = redir_bad;
`endif
                    end else begin
                        pc_d = pend_pc_q;
                    end
                end
            end
            default: begin // BOOT
                state_d = RUN;
            end
        endcase

        // BOOT, or RUN without accept: keep the request stable and capture
        // the event. A trap always wins. A redirect never replaces a
        // pending trap.
        if (state_q == BOOT || (state_q == RUN && !acc)) begin
            if (trap_i) begin
                pend_vld_d  = 1'b1;
                pend_trap_d = 1'b1;
                pend_pc_d   = trap_vec_i;
            end else if (redirect_i && !(pend_vld_q && pend_trap_q)) begin
                pend_vld_d  = 1'b1;
                pend_trap_d = 1'b0;
                pend_pc_d   = redir_tgt;
`ifdef PC_MISALIGN_TRAP_EN
                misalign_d  = redir_bad;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            fetch_vld_q <= 1'b0;
            fetch_pc_q  <= '0;
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_pc_q   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_vld_q <= fetch_vld_d;
            fetch_pc_q  <= fetch_pc_d;
            pend_vld_q  <= pend_vld_d;
            pend_trap_q <= pend_trap_d;
            pend_pc_q   <= pend_pc_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

endmodule
